// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronises, debounces and converts the front-panel push
// buttons into single-cycle press / release / auto-repeat step / long-press
// events. Every button is handled by an independent lane. The lanes do not
// share logic and do not give one button priority over another.
module btn_conditioner #(
  parameter int                 NUM_BTN         = 5,
  parameter int                 DEBOUNCE_CYCLES = 2_000_000,
  parameter int                 REPEAT_DELAY    = 50_000_000,
  parameter int                 REPEAT_PERIOD   = 10_000_000,
  parameter int                 LONG_CYCLES     = 200_000_000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = NUM_BTN'(5'b00011),
  parameter logic [NUM_BTN-1:0] LONG_MASK       = NUM_BTN'(5'b10000)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_step,
  output logic [NUM_BTN-1:0] btn_long
);

  localparam int DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_MAX_A = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_MAX   = (HOLD_MAX_A > LONG_CYCLES) ? HOLD_MAX_A : LONG_CYCLES;
  localparam int HC_W       = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HC_W-1:0] HC_ONE  = HC_W'(1);
  localparam logic [HC_W-1:0] HC_SAT  = '1;
  localparam logic [HC_W-1:0] HC_DLY  = HC_W'(REPEAT_DELAY);
  localparam logic [HC_W-1:0] HC_PER  = HC_W'(REPEAT_PERIOD);
  localparam logic [HC_W-1:0] HC_LONG = HC_W'(LONG_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RPT  = 2'd2
  } rpt_state_e;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      localparam bit RPT_EN  = REPEAT_MASK[gi];
      localparam bit LONG_EN = LONG_MASK[gi];

      logic            s1_reg, s2_reg;
      logic [DB_W-1:0] cnt_reg, cnt_next;
      logic            level_reg, level_next;
      logic            rise, fall;
      rpt_state_e      state_reg, state_next;
      logic [HC_W-1:0] hc_reg, hc_next;
      logic            step_next;
      logic [HC_W-1:0] lc_reg, lc_next;
      logic            long_flag_reg, long_flag_next;
      logic            long_next;
      logic            press_reg, release_reg, step_reg, long_reg;

      // Two-flop synchroniser for the asynchronous pin; s1 feeds only s2.
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= btn_raw[gi];
          s2_reg <= s1_reg;
        end
      end

      // Debounce: accept the synchronised level only after it has disagreed
      // with the current level for DEBOUNCE_CYCLES consecutive cycles.
      always_comb begin
        level_next = level_reg;
        cnt_next   = '0;
        if (s2_reg != level_reg) begin
          if (cnt_reg == DB_LAST) begin
            level_next = s2_reg;
          end else begin
            cnt_next = cnt_reg + DB_ONE;
          end
        end
      end

      // Edges are taken from the next level so that the pulses line up with
      // the first cycle in which btn_level shows the new value.
      assign rise = level_next & ~level_reg;
      assign fall = ~level_next & level_reg;

      // Auto-repeat: first step on press, then after REPEAT_DELAY, then every
      // REPEAT_PERIOD. A release or a completed long press stops the steps.
      always_comb begin
        state_next = state_reg;
        hc_next    = hc_reg;
        step_next  = 1'b0;
        if (!level_next) begin
          state_next = S_IDLE;
          hc_next    = '0;
        end else begin
          case (state_reg)
            S_IDLE: begin
              if (rise) begin
                step_next  = 1'b1;
                hc_next    = HC_ONE;
                state_next = S_WAIT;
              end
            end
            S_WAIT: begin
              if (RPT_EN && !long_flag_reg && hc_reg == HC_DLY) begin
                step_next  = 1'b1;
                hc_next    = HC_ONE;
                state_next = S_RPT;
              end else if (hc_reg != HC_SAT) begin
                hc_next = hc_reg + HC_ONE;
              end
            end
            S_RPT: begin
              if (!long_flag_reg && hc_reg == HC_PER) begin
                step_next = 1'b1;
                hc_next   = HC_ONE;
              end else if (hc_reg != HC_SAT) begin
                hc_next = hc_reg + HC_ONE;
              end
            end
            default: begin
              state_next = S_IDLE;
              hc_next    = '0;
            end
          endcase
        end
      end

      // Long press: count held cycles from the press and pulse once. The flag
      // suppresses further repeat steps until the button is released.
      always_comb begin
        lc_next        = lc_reg;
        long_flag_next = long_flag_reg;
        long_next      = 1'b0;
        if (!level_next) begin
          lc_next        = '0;
          long_flag_next = 1'b0;
        end else if (rise) begin
          lc_next        = HC_ONE;
          long_flag_next = 1'b0;
        end else if (LONG_EN && !long_flag_reg) begin
          if (lc_reg == HC_LONG) begin
            long_next      = 1'b1;
            long_flag_next = 1'b1;
          end else if (lc_reg != HC_SAT) begin
            lc_next = lc_reg + HC_ONE;
          end
        end
      end

      // Lane state and registered event outputs.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg       <= '0;
          level_reg     <= 1'b0;
          state_reg     <= S_IDLE;
          hc_reg        <= '0;
          lc_reg        <= '0;
          long_flag_reg <= 1'b0;
          press_reg     <= 1'b0;
          release_reg   <= 1'b0;
          step_reg      <= 1'b0;
          long_reg      <= 1'b0;
        end else begin
          cnt_reg       <= cnt_next;
          level_reg     <= level_next;
          state_reg     <= state_next;
          hc_reg        <= hc_next;
          lc_reg        <= lc_next;
          long_flag_reg <= long_flag_next;
          press_reg     <= rise;
          release_reg   <= fall;
          step_reg      <= step_next;
          long_reg      <= long_next;
        end
      end

      assign btn_level[gi]   = level_reg;
      assign btn_press[gi]   = press_reg;
      assign btn_release[gi] = release_reg;
      assign btn_step[gi]    = step_reg;
      assign btn_long[gi]    = long_reg;
    end
  endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner. It uses short timing parameters. Directed
// scenarios are followed by a randomized run, and that run is checked
// against a history-based reference model.
module tb_btn_conditioner;

  localparam int NB = 5;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;
  localparam int LG = 20;
  localparam int RN = 800;
  localparam logic [NB-1:0] RMASK = 5'b00011;
  localparam logic [NB-1:0] LMASK = 5'b10000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_step, btn_long;

  int checks = 0;
  int errors = 0;

  btn_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .LONG_CYCLES    (LG),
    .REPEAT_MASK    (RMASK),
    .LONG_MASK      (LMASK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_step   (btn_step),
    .btn_long   (btn_long)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with all pins low. The bench returns just after the last reset
  // edge. Raw pins driven right after this point count as "cycle 0".
  task automatic do_reset();
    btn_raw = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    btn_raw = '1;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (btn_level !== 5'b0) begin errors++; $display("FAIL reset_level got %b exp %b", btn_level, 5'b0); end
    checks++; if (btn_press !== 5'b0) begin errors++; $display("FAIL reset_press got %b exp %b", btn_press, 5'b0); end
    checks++; if (btn_release !== 5'b0) begin errors++; $display("FAIL reset_release got %b exp %b", btn_release, 5'b0); end
    checks++; if (btn_step !== 5'b0) begin errors++; $display("FAIL reset_step got %b exp %b", btn_step, 5'b0); end
    checks++; if (btn_long !== 5'b0) begin errors++; $display("FAIL reset_long got %b exp %b", btn_long, 5'b0); end
    $display("test_reset: outputs after reset level=%b press=%b step=%b long=%b", btn_level, btn_press, btn_step, btn_long);
    rst = 1'b0;
    do_reset();
  endtask

  // Up pressed at cycle 0 and held, then released after cycle 40.
  task automatic test_press_release();
    do_reset();
    btn_raw[0] = 1'b1;
    for (int c = 1; c <= 52; c++) begin
      tick();
      checks++; if (btn_level[0] !== (c >= 6 && c < 46)) begin errors++; $display("FAIL pr_level c=%0d got %b exp %b", c, btn_level[0], (c >= 6 && c < 46)); end
      checks++; if (btn_press[0] !== (c == 6)) begin errors++; $display("FAIL pr_press c=%0d got %b exp %b", c, btn_press[0], (c == 6)); end
      checks++; if (btn_release[0] !== (c == 46)) begin errors++; $display("FAIL pr_release c=%0d got %b exp %b", c, btn_release[0], (c == 46)); end
      if (c == 40) btn_raw[0] = 1'b0;
    end
    $display("test_press_release: up press at 6, release at 46 checked");
  endtask

  // Down bounces high for 3 cycles only; nothing must qualify.
  task automatic test_bounce();
    do_reset();
    btn_raw[1] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      checks++; if ({btn_level[1], btn_press[1], btn_step[1]} !== 3'b000) begin errors++; $display("FAIL bounce c=%0d got lvl/press/step %b exp 000", c, {btn_level[1], btn_press[1], btn_step[1]}); end
      if (c == 3) btn_raw[1] = 1'b0;
    end
    $display("test_bounce: 3-cycle glitch on down rejected");
  endtask

  // Up held 40 cycles: press step plus auto-repeat steps.
  task automatic test_repeat();
    logic exp;
    do_reset();
    btn_raw[0] = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      exp = (c == 6 || c == 16 || c == 21 || c == 26 || c == 31 || c == 36 || c == 41);
      checks++; if (btn_step[0] !== exp) begin errors++; $display("FAIL repeat_step c=%0d got %b exp %b", c, btn_step[0], exp); end
      if (c == 40) btn_raw[0] = 1'b0;
    end
    $display("test_repeat: up steps at 6,16,21,26,31,36,41 checked");
  endtask

  // Left held 40 cycles without repeat enabled: a single step only.
  task automatic test_no_repeat();
    do_reset();
    btn_raw[2] = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      checks++; if (btn_step[2] !== (c == 6)) begin errors++; $display("FAIL norpt_step c=%0d got %b exp %b", c, btn_step[2], (c == 6)); end
      if (c == 40) btn_raw[2] = 1'b0;
    end
    $display("test_no_repeat: left single step at 6 checked");
  endtask

  // Middle held 30 cycles gives one long pulse; held 15 cycles gives none.
  task automatic test_long();
    do_reset();
    btn_raw[4] = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      tick();
      checks++; if (btn_long[4] !== (c == 26)) begin errors++; $display("FAIL long30 c=%0d got %b exp %b", c, btn_long[4], (c == 26)); end
      checks++; if (btn_step[4] !== (c == 6)) begin errors++; $display("FAIL long30_step c=%0d got %b exp %b", c, btn_step[4], (c == 6)); end
      if (c == 30) btn_raw[4] = 1'b0;
    end
    do_reset();
    btn_raw[4] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      checks++; if (btn_long[4] !== 1'b0) begin errors++; $display("FAIL long15 c=%0d got %b exp 0", c, btn_long[4]); end
      if (c == 15) btn_raw[4] = 1'b0;
    end
    $display("test_long: middle long pulse at 26 for 30-cycle hold, none for 15-cycle hold");
  endtask

  // Up held, reset pulse in mid-hold: outputs clear and the press re-qualifies.
  task automatic test_reset_mid_hold();
    do_reset();
    btn_raw[0] = 1'b1;
    for (int c = 1; c <= 12; c++) tick();
    rst = 1'b1;
    tick();
    checks++; if ({btn_level, btn_press, btn_release, btn_step, btn_long} !== 25'b0) begin errors++; $display("FAIL midrst_clear c=13 got %h exp 0", {btn_level, btn_press, btn_release, btn_step, btn_long}); end
    rst = 1'b0;
    for (int c = 14; c <= 26; c++) begin
      tick();
      checks++; if (btn_press[0] !== (c == 19)) begin errors++; $display("FAIL midrst_press c=%0d got %b exp %b", c, btn_press[0], (c == 19)); end
      checks++; if (btn_level[0] !== (c >= 19)) begin errors++; $display("FAIL midrst_level c=%0d got %b exp %b", c, btn_level[0], (c >= 19)); end
    end
    $display("test_reset_mid_hold: cleared at 13, re-press at 19 checked");
  endtask

  // All five buttons at once: simultaneous press and step pulses.
  task automatic test_simultaneous();
    do_reset();
    btn_raw = '1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++; if (btn_press !== ((c == 6) ? 5'b11111 : 5'b00000)) begin errors++; $display("FAIL simul_press c=%0d got %b exp %b", c, btn_press, ((c == 6) ? 5'b11111 : 5'b00000)); end
      checks++; if (btn_step !== ((c == 6) ? 5'b11111 : 5'b00000)) begin errors++; $display("FAIL simul_step c=%0d got %b exp %b", c, btn_step, ((c == 6) ? 5'b11111 : 5'b00000)); end
    end
    $display("test_simultaneous: all buttons pressed together at 6");
  endtask

  // Random bouncy/held waveforms on all pins checked against a model that
  // derives events from the raw history and the hold durations.
  task automatic test_random();
    logic [NB-1:0] raw_hist [RN];
    logic [NB-1:0] lv       [RN];
    logic [NB-1:0] e_press  [RN];
    logic [NB-1:0] e_rel    [RN];
    logic [NB-1:0] e_step   [RN];
    logic [NB-1:0] e_long   [RN];
    logic [NB-1:0] rmask, lmask;
    int shown;
    rmask = RMASK;
    lmask = LMASK;
    shown = 0;
    for (int t = 0; t < RN; t++) begin
      raw_hist[t] = '0; lv[t] = '0; e_press[t] = '0; e_rel[t] = '0; e_step[t] = '0; e_long[t] = '0;
    end
    // Stimulus: alternating segments, a quarter of them short bounces.
    for (int b = 0; b < NB; b++) begin
      int t;
      logic v;
      t = 0;
      v = 1'b0;
      while (t < RN) begin
        int d;
        v = ~v;
        d = ($urandom_range(3) == 0) ? int'($urandom_range(5, 1)) : int'($urandom_range(60, 5));
        for (int k = 0; k < d && t < RN; k++) begin
          raw_hist[t][b] = v;
          t++;
        end
      end
    end
    // Level: the pin is seen 3 edges after it is driven; the level flips once
    // the last DB seen samples all disagree with it.
    for (int b = 0; b < NB; b++) begin
      logic cur;
      cur = 1'b0;
      for (int t = 0; t < RN; t++) begin
        logic flip;
        flip = 1'b1;
        for (int j = 3; j < 3 + DB; j++) begin
          if (((t - j) < 0 ? 1'b0 : raw_hist[t - j][b]) == cur) flip = 1'b0;
        end
        if (flip) cur = ~cur;
        lv[t][b] = cur;
      end
    end
    // Events from each hold interval [press, release).
    for (int b = 0; b < NB; b++) begin
      for (int p = 0; p < RN; p++) begin
        logic prev;
        prev = (p > 0) ? lv[p - 1][b] : 1'b0;
        if (prev && !lv[p][b]) e_rel[p][b] = 1'b1;
        if (!prev && lv[p][b]) begin
          int r;
          e_press[p][b] = 1'b1;
          r = p + 1;
          while (r < RN && lv[r][b]) r++;
          for (int u = p; u < r; u++) begin
            int h;
            h = u - p;
            if (h == 0) e_step[u][b] = 1'b1;
            else if (rmask[b] && h >= RD && ((h - RD) % RP) == 0 && (!lmask[b] || h <= LG)) e_step[u][b] = 1'b1;
            if (lmask[b] && h == LG) e_long[u][b] = 1'b1;
          end
        end
      end
    end
    do_reset();
    for (int t = 0; t < RN; t++) begin
      tick();
      checks++; if (btn_level !== lv[t]) begin errors++; if (shown < 30) $display("FAIL rnd_level t=%0d got %b exp %b", t, btn_level, lv[t]); shown++; end
      checks++; if (btn_press !== e_press[t]) begin errors++; if (shown < 30) $display("FAIL rnd_press t=%0d got %b exp %b", t, btn_press, e_press[t]); shown++; end
      checks++; if (btn_release !== e_rel[t]) begin errors++; if (shown < 30) $display("FAIL rnd_release t=%0d got %b exp %b", t, btn_release, e_rel[t]); shown++; end
      checks++; if (btn_step !== e_step[t]) begin errors++; if (shown < 30) $display("FAIL rnd_step t=%0d got %b exp %b", t, btn_step, e_step[t]); shown++; end
      checks++; if (btn_long !== e_long[t]) begin errors++; if (shown < 30) $display("FAIL rnd_long t=%0d got %b exp %b", t, btn_long, e_long[t]); shown++; end
      btn_raw = raw_hist[t];
    end
    $display("test_random: %0d cycles of random pin activity compared", RN);
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_repeat();
    test_no_repeat();
    test_long();
    test_reset_mid_hold();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
